// File: rtl/risc_v_32i.sv
// Shared RV32I definitions: datapath widths, branch selector encodings and
// the branch-resolution controller state and result types.
package risc_v_32i;

  localparam int unsigned REG_SIZE          = 32;
  localparam int unsigned BRANCH_SEL_LENGTH = 3;

  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BEQ      = BRANCH_SEL_LENGTH'(0);
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BLT      = BRANCH_SEL_LENGTH'(1);
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BGE      = BRANCH_SEL_LENGTH'(2);
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BLTU     = BRANCH_SEL_LENGTH'(3);
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BGEU     = BRANCH_SEL_LENGTH'(4);
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BNE      = BRANCH_SEL_LENGTH'(5);
  localparam logic [BRANCH_SEL_LENGTH-1:0] OP_BUNKNOWN = BRANCH_SEL_LENGTH'(6);

  localparam logic [REG_SIZE-1:0] PC_STEP = REG_SIZE'(4);

  typedef enum logic [1:0] {
    BRC_IDLE,
    BRC_EVAL,
    BRC_RESP
  } brc_state_e;

  typedef struct packed {
    logic                taken;
    logic                redirect;
    logic                misalign;
    logic                illegal;
    logic [REG_SIZE-1:0] pc;
  } brc_result_t;

  // Anything at or above OP_BUNKNOWN is not a defined branch.
  function automatic logic sel_illegal(input logic [BRANCH_SEL_LENGTH-1:0] sel);
    return sel >= OP_BUNKNOWN;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode-side request and fetch/hazard-side response channels of the
// branch-resolution controller.
interface branch_resolve_ctrl_if;
  import risc_v_32i::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [REG_SIZE-1:0]          in_pc;
  logic [REG_SIZE-1:0]          in_rs1;
  logic [REG_SIZE-1:0]          in_rs2;
  logic [REG_SIZE-1:0]          in_imm;
  logic [BRANCH_SEL_LENGTH-1:0] in_sel;
  logic                         in_pred;

  logic                         out_valid;
  logic                         out_ready;
  logic                         out_taken;
  logic                         out_redirect;
  logic [REG_SIZE-1:0]          out_pc;
  logic                         out_misalign;
  logic                         out_illegal;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_sel, in_pred, out_ready,
    input  in_ready, out_valid, out_taken, out_redirect, out_pc, out_misalign, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_sel, in_pred, out_ready,
    output in_ready, out_valid, out_taken, out_redirect, out_pc, out_misalign, out_illegal
  );

endinterface

// File: rtl/comparator.sv
// Shared EX-stage branch comparator; result is the branch condition.
module comparator
  import risc_v_32i::*;
(
  input  logic [REG_SIZE-1:0]          a,
  input  logic [REG_SIZE-1:0]          b,
  input  logic [BRANCH_SEL_LENGTH-1:0] sel,
  output logic                         result
);

  always_comb begin
    result = 1'b0;
    case (sel)
      OP_BEQ:  result = (a == b);
      OP_BNE:  result = (a != b);
      OP_BLT:  result = ($signed(a) <  $signed(b));
      OP_BGE:  result = ($signed(a) >= $signed(b));
      OP_BLTU: result = (a <  b);
      OP_BGEU: result = (a >= b);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves one conditional branch at a time through the shared comparator and
// hands taken/redirect/target back to fetch, with saturating perf counters.
module branch_resolve_ctrl
  import risc_v_32i::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter logic [1:0]  ALIGN_MASK = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  branch_resolve_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]      br_cnt,
  output logic [CNT_W-1:0]      mis_cnt
);

  brc_state_e                   state_q, state_d;
  logic                         capture, resolve, deliver;
  logic [REG_SIZE-1:0]          pc_q, rs1_q, rs2_q, imm_q;
  logic [BRANCH_SEL_LENGTH-1:0] sel_q;
  logic                         pred_q;
  logic                         cond;
  logic [REG_SIZE-1:0]          target;
  brc_result_t                  res_d, res_q;
  logic                         in_ready_q, out_valid_q;

  comparator u_cmp (
    .a      (rs1_q),
    .b      (rs2_q),
    .sel    (sel_q),
    .result (cond)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BRC_IDLE;
    else        state_q <= state_d;
  end

  // Flush overrides every transition, including a same-edge handshake.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    resolve = 1'b0;
    deliver = 1'b0;
    if (flush) begin
      state_d = BRC_IDLE;
    end else begin
      case (state_q)
        BRC_IDLE: if (bus.in_valid) begin
          capture = 1'b1;
          state_d = BRC_EVAL;
        end
        BRC_EVAL: begin
          resolve = 1'b1;
          state_d = BRC_RESP;
        end
        BRC_RESP: if (bus.out_ready) begin
          deliver = 1'b1;
          state_d = BRC_IDLE;
        end
        default: state_d = BRC_IDLE;
      endcase
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == BRC_IDLE);
      out_valid_q <= (state_d == BRC_RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      sel_q  <= '0;
      pred_q <= 1'b0;
    end else if (capture) begin
      pc_q   <= bus.in_pc;
      rs1_q  <= bus.in_rs1;
      rs2_q  <= bus.in_rs2;
      imm_q  <= bus.in_imm;
      sel_q  <= bus.in_sel;
      pred_q <= bus.in_pred;
    end
  end

  assign target = pc_q + imm_q;

  // Misaligned targets are flagged but delivered raw; the trap is raised downstream.
  always_comb begin
    res_d.illegal  = sel_illegal(sel_q);
    res_d.taken    = cond && !res_d.illegal;
    res_d.redirect = res_d.taken != pred_q;
    res_d.misalign = res_d.taken && ((target[1:0] & ALIGN_MASK) != 2'b00);
    res_d.pc       = res_d.taken ? target : pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       res_q <= '0;
    else if (resolve) res_q <= res_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (deliver) begin
      if (br_cnt != '1)                    br_cnt  <= br_cnt + CNT_W'(1);
      if (res_q.redirect && mis_cnt != '1) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_taken    = res_q.taken;
  assign bus.out_redirect = res_q.redirect;
  assign bus.out_pc       = res_q.pc;
  assign bus.out_misalign = res_q.misalign;
  assign bus.out_illegal  = res_q.illegal;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: an occupancy/latency model with a
// per-cycle compare process, plus hand-computed literal checks.
module tb_branch_resolve_ctrl;
  import risc_v_32i::*;

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  branch_resolve_ctrl_if bus();

  branch_resolve_ctrl #(.CNT_W(CNT_W), .ALIGN_MASK(2'b11)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus),
    .br_cnt  (br_cnt),
    .mis_cnt (mis_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        taken;
    logic        redirect;
    logic        misalign;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  // Reference rules computed with wide integer arithmetic.
  function automatic exp_t predict(input logic [31:0] pc, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] imm,
                                   input logic [2:0] sel, input logic pred);
    exp_t   e;
    longint sa, sb, ua, ub, tgt, seq;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    tgt = (longint'(pc) + longint'(imm)) % 64'sh1_0000_0000;
    seq = (longint'(pc) + 64'sd4) % 64'sh1_0000_0000;
    e.illegal = 1'b0;
    e.taken   = 1'b0;
    if      (sel == OP_BEQ)  e.taken = (ua == ub);
    else if (sel == OP_BNE)  e.taken = (ua != ub);
    else if (sel == OP_BLT)  e.taken = (sa <  sb);
    else if (sel == OP_BGE)  e.taken = (sa >= sb);
    else if (sel == OP_BLTU) e.taken = (ua <  ub);
    else if (sel == OP_BGEU) e.taken = (ua >= ub);
    else                     e.illegal = 1'b1;
    e.redirect = (e.taken != pred);
    e.misalign = e.taken && ((tgt % 4) != 0);
    e.pc       = e.taken ? 32'(tgt) : 32'(seq);
    return e;
  endfunction

  // Model: an accepted op becomes visible one edge later and stays until consumed.
  logic             have_op = 1'b0;
  int               age     = 0;
  exp_t             cur;
  logic [CNT_W-1:0] m_br    = '0;
  logic [CNT_W-1:0] m_mis   = '0;
  logic             preload = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_op = 1'b0;
      age     = 0;
      m_br    = '0;
      m_mis   = '0;
    end else begin
      if (preload) m_br = CNT_MAX;
      if (flush) begin
        have_op = 1'b0;
      end else if (!have_op) begin
        if (bus.in_valid) begin
          cur     = predict(bus.in_pc, bus.in_rs1, bus.in_rs2, bus.in_imm, bus.in_sel, bus.in_pred);
          have_op = 1'b1;
          age     = 0;
        end
      end else if (age >= 1 && bus.out_ready) begin
        have_op = 1'b0;
        if (m_br != CNT_MAX) m_br = m_br + 1;
        if (cur.redirect && m_mis != CNT_MAX) m_mis = m_mis + 1;
      end else begin
        age++;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(bus.in_ready), 64'(!have_op));
    chk("out_valid", 64'(bus.out_valid), 64'(have_op && age >= 1));
    chk("br_cnt", 64'(br_cnt), 64'(m_br));
    chk("mis_cnt", 64'(mis_cnt), 64'(m_mis));
    if (have_op && age >= 1) begin
      chk("out_taken", 64'(bus.out_taken), 64'(cur.taken));
      chk("out_redirect", 64'(bus.out_redirect), 64'(cur.redirect));
      chk("out_pc", 64'(bus.out_pc), 64'(cur.pc));
      chk("out_misalign", 64'(bus.out_misalign), 64'(cur.misalign));
      chk("out_illegal", 64'(bus.out_illegal), 64'(cur.illegal));
    end
  end

  // All tasks are entered one time unit after a rising edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [2:0] sel, input logic pred);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_imm   = imm;
    bus.in_sel   = sel;
    bus.in_pred  = pred;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) chk("valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic ack(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [31:0] snap_pc;
  logic        snap_taken;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.in_sel    = OP_BEQ;
    bus.in_pred   = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_br_cnt", 64'(br_cnt), 64'd0);

    // BEQ taken against a not-taken prediction, consumer always ready.
    bus.out_ready = 1'b1;
    send(32'h100, 32'd5, 32'd5, 32'h20, OP_BEQ, 1'b0);
    chk("t1_eval_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_eval_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_taken", 64'(bus.out_taken), 64'd1);
    chk("t1_redirect", 64'(bus.out_redirect), 64'd1);
    chk("t1_pc", 64'(bus.out_pc), 64'h120);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("t1_mis_cnt", 64'(mis_cnt), 64'd1);
    chk("t1_br_cnt", 64'(br_cnt), 64'd1);

    // Signed vs unsigned less-than on the same operands.
    send(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, OP_BLT, 1'b1);
    wait_valid();
    chk("t2_blt_taken", 64'(bus.out_taken), 64'd1);
    chk("t2_blt_redirect", 64'(bus.out_redirect), 64'd0);
    chk("t2_blt_pc", 64'(bus.out_pc), 64'h240);
    ack(0);
    send(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, OP_BLTU, 1'b1);
    wait_valid();
    chk("t2_bltu_taken", 64'(bus.out_taken), 64'd0);
    chk("t2_bltu_pc", 64'(bus.out_pc), 64'h204);
    ack(0);
    chk("t2_br_cnt", 64'(br_cnt), 64'd3);
    chk("t2_mis_cnt", 64'(mis_cnt), 64'd2);

    // Back-pressure: result held stable for five cycles.
    send(32'h300, 32'd7, 32'd9, 32'h10, OP_BGE, 1'b0);
    wait_valid();
    snap_pc    = bus.out_pc;
    snap_taken = bus.out_taken;
    chk("t3_pc", 64'(snap_pc), 64'h304);
    repeat (5) begin
      @(posedge clk); #1;
      chk("t3_hold_pc", 64'(bus.out_pc), 64'(snap_pc));
      chk("t3_hold_taken", 64'(bus.out_taken), 64'(snap_taken));
      chk("t3_hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("t3_hold_br_cnt", 64'(br_cnt), 64'd3);
    end
    ack(0);
    chk("t3_br_cnt", 64'(br_cnt), 64'd4);

    // Flush in EVAL, then flush colliding with a handshake in RESP.
    send(32'h400, 32'd1, 32'd2, 32'h8, OP_BNE, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t4_eval_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t4_eval_valid", 64'(bus.out_valid), 64'd0);
    send(32'h500, 32'd1, 32'd2, 32'h8, OP_BNE, 1'b0);
    @(posedge clk); #1;
    chk("t4_resp_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    chk("t4_flush_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t4_flush_br_cnt", 64'(br_cnt), 64'd4);
    chk("t4_flush_mis_cnt", 64'(mis_cnt), 64'd2);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("t4_ignored_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("t4_ignored_valid", 64'(bus.out_valid), 64'd0);

    // Wrap-around, misaligned target, illegal selectors.
    send(32'hFFFF_FFFC, 32'd1, 32'd2, 32'd8, OP_BNE, 1'b1);
    wait_valid();
    chk("t5_wrap_pc", 64'(bus.out_pc), 64'h4);
    chk("t5_wrap_misalign", 64'(bus.out_misalign), 64'd0);
    ack(0);
    send(32'h1000, 32'd3, 32'd3, 32'd2, OP_BEQ, 1'b1);
    wait_valid();
    chk("t5_mis_flag", 64'(bus.out_misalign), 64'd1);
    chk("t5_mis_pc", 64'(bus.out_pc), 64'h1002);
    ack(1);
    send(32'h1000, 32'd3, 32'd3, 32'h10, OP_BUNKNOWN, 1'b1);
    wait_valid();
    chk("t5_unk_illegal", 64'(bus.out_illegal), 64'd1);
    chk("t5_unk_taken", 64'(bus.out_taken), 64'd0);
    chk("t5_unk_redirect", 64'(bus.out_redirect), 64'd1);
    chk("t5_unk_pc", 64'(bus.out_pc), 64'h1004);
    ack(0);
    send(32'h2000, 32'd3, 32'd3, 32'h10, 3'd7, 1'b0);
    wait_valid();
    chk("t5_sel7_illegal", 64'(bus.out_illegal), 64'd1);
    ack(0);
    chk("t5_br_cnt", 64'(br_cnt), 64'd8);
    chk("t5_mis_cnt", 64'(mis_cnt), 64'd3);

    // Saturation from a preloaded count, then async reset while in RESP.
    @(negedge clk); #1;
    force dut.br_cnt = CNT_MAX;
    #1 release dut.br_cnt;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    send(32'h3000, 32'd4, 32'd4, 32'h8, OP_BEQ, 1'b0);
    wait_valid();
    ack(0);
    chk("t6_br_sat", 64'(br_cnt), 64'hFFFF_FFFF);
    chk("t6_mis_cnt", 64'(mis_cnt), 64'd4);
    send(32'h3000, 32'd4, 32'd4, 32'h8, OP_BEQ, 1'b0);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t6_rst_taken", 64'(bus.out_taken), 64'd0);
    chk("t6_rst_pc", 64'(bus.out_pc), 64'd0);
    chk("t6_rst_br_cnt", 64'(br_cnt), 64'd0);
    chk("t6_rst_mis_cnt", 64'(mis_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
